// File: rtl/sdf_bitrev_reorder.sv
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
// Ping-pong reorder of bit-reversed SDF FFT frames into natural-order bursts of N gapless beats;
// first beat 3 cycles after the frame's last input, no backpressure on either side.
module sdf_bitrev_reorder #(
   parameter int FFT_STAGE = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       di_en,
   input  logic [`DATA_IN_WIDTH-1:0]  di_re,
   input  logic [`DATA_IN_WIDTH-1:0]  di_im,
   output logic                       do_en,
   output logic [`DATA_IN_WIDTH-1:0]  do_re,
   output logic [`DATA_IN_WIDTH-1:0]  do_im,
   output logic [FFT_STAGE-1:0]       do_idx,
   output logic                       do_last
);
   localparam int W  = `DATA_IN_WIDTH;
   localparam int N  = 1 << FFT_STAGE;
   localparam int AW = FFT_STAGE + 1;

   typedef enum logic {IDLE, READ} state_t;

   function automatic logic [FFT_STAGE-1:0] bitrev(input logic [FFT_STAGE-1:0] a);
      logic [FFT_STAGE-1:0] r;
      for (int i = 0; i < FFT_STAGE; i++) r[i] = a[FFT_STAGE-1-i];
      return r;
   endfunction

   logic [2*W-1:0]       mem [0:2*N-1];
   logic [FFT_STAGE-1:0] wr_cnt_q, wr_cnt_d;
   logic                 wr_bank_q, wr_bank_d;
   logic                 frame_done_q, frame_done_d;
   state_t               state_q, state_d;
   logic [FFT_STAGE-1:0] rd_cnt_q, rd_cnt_d;
   logic                 rd_bank_q, rd_bank_d;
   logic                 rd_en;
   logic [2*W-1:0]       ram_dat_q;
   logic                 rd_vld_q;
   logic [FFT_STAGE-1:0] rd_idx_q;
   logic                 do_en_q, do_last_q;
   logic [FFT_STAGE-1:0] do_idx_q;
   logic [W-1:0]         do_re_q, do_im_q;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr, rd_addr;

   assign wr_en   = di_en && !rst;
   assign wr_addr = {wr_bank_q, bitrev(wr_cnt_q)};
   assign rd_addr = {rd_bank_q, rd_cnt_q};

   always_comb begin
      wr_cnt_d     = wr_cnt_q;
      wr_bank_d    = wr_bank_q;
      frame_done_d = 1'b0;
      if (di_en) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
         if (&wr_cnt_q) begin
            wr_bank_d    = ~wr_bank_q;
            frame_done_d = 1'b1;
         end
      end
   end

   // wr_bank has already flipped when frame_done is seen, so the finished bank is its complement.
   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_done_q) begin
               state_d   = READ;
               rd_bank_d = ~wr_bank_q;
               rd_cnt_d  = '0;
            end
         end
         READ: begin
            rd_en    = 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (&rd_cnt_q) begin
               if (frame_done_q) begin
                  rd_bank_d = ~wr_bank_q;
                  rd_cnt_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= {di_re, di_im};
      if (rd_en) ram_dat_q <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         frame_done_q <= 1'b0;
         state_q      <= IDLE;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_idx_q     <= '0;
         do_en_q      <= 1'b0;
         do_last_q    <= 1'b0;
         do_idx_q     <= '0;
         do_re_q      <= '0;
         do_im_q      <= '0;
      end else begin
         wr_cnt_q     <= wr_cnt_d;
         wr_bank_q    <= wr_bank_d;
         frame_done_q <= frame_done_d;
         state_q      <= state_d;
         rd_cnt_q     <= rd_cnt_d;
         rd_bank_q    <= rd_bank_d;
         rd_vld_q     <= rd_en;
         rd_idx_q     <= rd_cnt_q;
         do_en_q      <= rd_vld_q;
         do_last_q    <= rd_vld_q && (&rd_idx_q);
         do_idx_q     <= rd_vld_q ? rd_idx_q : '0;
         do_re_q      <= rd_vld_q ? ram_dat_q[2*W-1:W] : '0;
         do_im_q      <= rd_vld_q ? ram_dat_q[W-1:0] : '0;
      end
   end

   assign do_en   = do_en_q;
   assign do_last = do_last_q;
   assign do_idx  = do_idx_q;
   assign do_re   = do_re_q;
   assign do_im   = do_im_q;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
`timescale 1ns/1ps
// Scoreboard bench: an 8-point and a 64-point instance, natural-order beats queued per frame.
module tb_sdf_bitrev_reorder;
   localparam int W = `DATA_IN_WIDTH;

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [5:0]   idx;
      logic         last;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         di_en3, di_en6;
   logic [W-1:0] di_re3, di_im3, di_re6, di_im6;
   logic         do_en3, do_en6, do_last3, do_last6;
   logic [W-1:0] do_re3, do_im3, do_re6, do_im6;
   logic [2:0]   do_idx3;
   logic [5:0]   do_idx6;

   int    vectors = 0;
   int    miscompares = 0;
   beat_t q3[$];
   beat_t q6[$];
   beat_t got3, exp3, got6, exp6;
   int    run3 = 0, max_run3 = 0, run6 = 0, max_run6 = 0;

   always #5 clk = ~clk;

   sdf_bitrev_reorder #(.FFT_STAGE(3)) u_dut3 (
      .clk(clk), .rst(rst), .di_en(di_en3), .di_re(di_re3), .di_im(di_im3),
      .do_en(do_en3), .do_re(do_re3), .do_im(do_im3), .do_idx(do_idx3), .do_last(do_last3)
   );

   sdf_bitrev_reorder #(.FFT_STAGE(6)) u_dut6 (
      .clk(clk), .rst(rst), .di_en(di_en6), .di_re(di_re6), .di_im(di_im6),
      .do_en(do_en6), .do_re(do_re6), .do_im(do_im6), .do_idx(do_idx6), .do_last(do_last6)
   );

   function automatic int brev(input int a, input int bits);
      int r = 0;
      for (int i = 0; i < bits; i++) if (a[i]) r = r | (1 << (bits - 1 - i));
      return r;
   endfunction

   function automatic beat_t mk(input logic [W-1:0] re, input logic [W-1:0] im,
                                input int idx, input logic last);
      beat_t b;
      b.re   = re;
      b.im   = im;
      b.idx  = idx[5:0];
      b.last = last;
      return b;
   endfunction

   always @(negedge clk) begin
      if (do_en3) begin
         run3 = run3 + 1;
         if (run3 > max_run3) max_run3 = run3;
         vectors++;
         assert (q3.size() > 0) else begin
            miscompares++;
            $error("FAIL unexpected_beat3 observed idx=%0d re=%h, expected no output", do_idx3, do_re3);
         end
         if (q3.size() > 0) begin
            exp3 = q3.pop_front();
            got3 = mk(do_re3, do_im3, int'(do_idx3), do_last3);
            vectors++;
            assert (got3 === exp3) else begin
               miscompares++;
               $error("FAIL beat3 observed re=%h im=%h idx=%0d last=%b expected re=%h im=%h idx=%0d last=%b",
                      got3.re, got3.im, got3.idx, got3.last, exp3.re, exp3.im, exp3.idx, exp3.last);
            end
         end
      end else begin
         run3 = 0;
      end
   end

   always @(negedge clk) begin
      if (do_en6) begin
         run6 = run6 + 1;
         if (run6 > max_run6) max_run6 = run6;
         vectors++;
         assert (q6.size() > 0) else begin
            miscompares++;
            $error("FAIL unexpected_beat6 observed idx=%0d re=%h, expected no output", do_idx6, do_re6);
         end
         if (q6.size() > 0) begin
            exp6 = q6.pop_front();
            got6 = mk(do_re6, do_im6, int'(do_idx6), do_last6);
            vectors++;
            assert (got6 === exp6) else begin
               miscompares++;
               $error("FAIL beat6 observed re=%h im=%h idx=%0d last=%b expected re=%h im=%h idx=%0d last=%b",
                      got6.re, got6.im, got6.idx, got6.last, exp6.re, exp6.im, exp6.idx, exp6.last);
            end
         end
      end else begin
         run6 = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send3(input logic [W-1:0] re, input logic [W-1:0] im);
      di_en3 = 1'b1; di_re3 = re; di_im3 = im;
      cyc();
      di_en3 = 1'b0;
   endtask

   task automatic send6(input logic [W-1:0] re, input logic [W-1:0] im);
      di_en6 = 1'b1; di_re6 = re; di_im6 = im;
      cyc();
      di_en6 = 1'b0;
   endtask

   // Frame value at natural index k is base+k (re) and 100+base+k (im).
   task automatic frame3(input int base, input bit gapped);
      int k;
      for (int j = 0; j < 8; j++) begin
         k = brev(j, 3);
         send3(W'(base + k), W'(100 + base + k));
         if (gapped && (j == 2 || j == 5)) repeat (3) cyc();
      end
      for (int n = 0; n < 8; n++) q3.push_back(mk(W'(base + n), W'(100 + base + n), n, n == 7));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((q3.size() != 0 || q6.size() != 0) && n < 300) begin
         cyc();
         n++;
      end
      repeat (4) cyc();
      vectors++;
      assert (q3.size() + q6.size() == 0) else begin
         miscompares++;
         $error("FAIL %s_drain observed %0d beats outstanding, expected 0", tag, q3.size() + q6.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] vmax, vmin;
      int           k;
      int           n;
      bit           found;
      vmax = {1'b0, {(W-1){1'b1}}};
      vmin = {1'b1, {(W-1){1'b0}}};

      rst = 1'b1;
      di_en3 = 1'b0; di_re3 = '0; di_im3 = '0;
      di_en6 = 1'b0; di_re6 = '0; di_im6 = '0;
      repeat (3) cyc();
      @(negedge clk);
      vectors++;
      assert ({do_en3, do_last3, do_idx3, do_re3, do_im3} === '0) else begin
         miscompares++;
         $error("FAIL reset3 observed en=%b last=%b idx=%0d re=%h im=%h expected all 0",
                do_en3, do_last3, do_idx3, do_re3, do_im3);
      end
      vectors++;
      assert ({do_en6, do_last6, do_idx6, do_re6, do_im6} === '0) else begin
         miscompares++;
         $error("FAIL reset6 observed en=%b last=%b idx=%0d re=%h im=%h expected all 0",
                do_en6, do_last6, do_idx6, do_re6, do_im6);
      end
      cyc();
      rst = 1'b0;
      cyc();

      // Single frame plus first-beat latency.
      frame3(0, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         assert (do_en3 === (c == 3)) else begin
            miscompares++;
            $error("FAIL latency_edge%0d observed do_en=%b expected %b", c, do_en3, c == 3);
         end
      end
      drain("single");

      // Four frames with di_en held high throughout.
      max_run3 = 0;
      for (int f = 0; f < 4; f++) frame3(8 * f, 1'b0);
      drain("b2b");
      vectors++;
      assert (max_run3 == 32) else begin
         miscompares++;
         $error("FAIL b2b_contiguous observed run=%0d expected 32", max_run3);
      end

      // Gaps inside the input frame.
      max_run3 = 0;
      frame3(0, 1'b1);
      drain("gapped");
      vectors++;
      assert (max_run3 == 8) else begin
         miscompares++;
         $error("FAIL gapped_contiguous observed run=%0d expected 8", max_run3);
      end

      // Partial frame discarded by reset; di_en during reset ignored.
      for (int j = 0; j < 5; j++) send3(W'(50 + j), W'(150 + j));
      rst = 1'b1;
      di_en3 = 1'b1; di_re3 = W'(99); di_im3 = W'(199);
      cyc();
      rst = 1'b0;
      di_en3 = 1'b0;
      frame3(10, 1'b0);
      drain("rst_frame");

      // 64-point frame of signed extremes.
      max_run6 = 0;
      for (int j = 0; j < 64; j++) begin
         k = brev(j, 6);
         send6(k[0] ? vmin : vmax, k[1] ? vmin : vmax);
      end
      for (int m = 0; m < 64; m++)
         q6.push_back(mk(m[0] ? vmin : vmax, m[1] ? vmin : vmax, m, m == 63));
      drain("extremes");
      vectors++;
      assert (max_run6 == 64) else begin
         miscompares++;
         $error("FAIL extremes_contiguous observed run=%0d expected 64", max_run6);
      end

      // Reset during beat 3 of a burst.
      frame3(40, 1'b0);
      n = 0;
      found = 1'b0;
      while (!found && n < 50) begin
         @(negedge clk);
         if (do_en3 && do_idx3 == 3'd3) found = 1'b1;
         n++;
      end
      vectors++;
      assert (found) else begin
         miscompares++;
         $error("FAIL rst_read_beat3 observed none within %0d cycles, expected beat 3", n);
      end
      #1;
      rst = 1'b1;
      q3.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         vectors++;
         assert ({do_en3, do_last3, do_re3} === '0) else begin
            miscompares++;
            $error("FAIL rst_read_quiet%0d observed en=%b last=%b re=%h expected 0 0 0",
                   c, do_en3, do_last3, do_re3);
         end
      end
      cyc();
      frame3(60, 1'b0);
      drain("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
